// File: rtl/cnt_cap_pkg.sv
// Shared defaults and helpers for the counter-capture FIFO and its storage sub-block.
package cnt_cap_pkg;

    localparam int DW_DEF    = 32'sd4;
    localparam int DEPTH_DEF = 32'sd4;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FWFT FIFO with a registered head word, separate occupancy counter and
// pointers that wrap modulo DEPTH. Writes into a full FIFO are only taken alongside a read.
module sync_fifo
    import cnt_cap_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [DW-1:0]             wr_data,
    input  logic                      rd_en,
    output logic [DW-1:0]             rd_data,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic [DW-1:0] head_r;
    logic [DW-1:0] head_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          wr_acc_s;
    logic          rd_acc_s;

    assign full_s   = (level_r == LW'(DEPTH));
    assign empty_s  = (level_r == '0);
    assign rd_acc_s = rd_en && !empty_s;
    assign wr_acc_s = wr_en && (!full_s || rd_acc_s);

    // Next occupancy, read pointer and head word.
    always_comb begin
        level_nxt_s  = level_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = head_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_nxt_s = level_r + LW'(1'b1);
            2'b01:   level_nxt_s = level_r - LW'(1'b1);
            default: level_nxt_s = level_r;
        endcase
        if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // The word being written this edge becomes the head when it lands at the new read slot.
        if (level_nxt_s == '0) begin
            head_nxt_s = head_r;
        end else if (wr_acc_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            head_r   <= '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            head_r   <= head_nxt_s;
        end
    end

    // Storage array; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = head_r;
    assign level   = level_r;
    assign full    = full_s;
    assign empty   = empty_s;

endmodule

// File: rtl/cnt_capture_fifo.sv
// Captures an enable-gated counter into a hold register and a FWFT FIFO drained by
// valid/ready, with a sticky flag for samples dropped while full.
module cnt_capture_fifo
    import cnt_cap_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [DW-1:0]             cnt_i,
    output logic [DW-1:0]             hold_o,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic [level_w(DEPTH)-1:0] level_o,
    output logic                      ovf_o,
    input  logic                      ovf_clr
);

    logic [DW-1:0] hold_r;
    logic          ovf_r;
    logic          ovf_nxt_s;
    logic          drop_s;
    logic          full_s;
    logic          empty_s;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (en_i),
        .wr_data (cnt_i),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .level   (level_o),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Drop decision and sticky overflow; a drop outranks a same-cycle clear.
    always_comb begin
        drop_s    = en_i && full_s && !out_ready;
        ovf_nxt_s = ovf_r;
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Hold register and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (en_i) begin
                hold_r <= cnt_i;
            end
            ovf_r <= ovf_nxt_s;
        end
    end

    assign hold_o    = hold_r;
    assign ovf_o     = ovf_r;
    assign out_valid = !empty_s;

endmodule
